// File: rtl/alu_arbiter_if.sv
// Requester and shared-ALU signal bundle for alu_arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface alu_arbiter_if;
  logic        req0_valid_i;
  logic        req1_valid_i;
  logic [2:0]  req0_op_i;
  logic [2:0]  req1_op_i;
  logic [31:0] req0_a_i;
  logic [31:0] req0_b_i;
  logic [31:0] req1_a_i;
  logic [31:0] req1_b_i;
  logic        req0_ready_o;
  logic        req1_ready_o;

  logic        alu_start_o;
  logic [2:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [31:0] alu_result_i;
  logic        alu_done_i;

  logic        resp0_valid_o;
  logic        resp1_valid_o;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic        busy_o;

  modport slave (
    input  req0_valid_i, req1_valid_i, req0_op_i, req1_op_i,
           req0_a_i, req0_b_i, req1_a_i, req1_b_i,
           alu_result_i, alu_done_i,
    output req0_ready_o, req1_ready_o,
           alu_start_o, alu_op_o, alu_a_o, alu_b_o,
           resp0_valid_o, resp1_valid_o, resp_data_o, resp_err_o, busy_o
  );

  modport master (
    output req0_valid_i, req1_valid_i, req0_op_i, req1_op_i,
           req0_a_i, req0_b_i, req1_a_i, req1_b_i,
           alu_result_i, alu_done_i,
    input  req0_ready_o, req1_ready_o,
           alu_start_o, alu_op_o, alu_a_o, alu_b_o,
           resp0_valid_o, resp1_valid_o, resp_data_o, resp_err_o, busy_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU.
// One operation in flight; a 16-cycle completion timeout returns an error response.
module alu_arbiter (
  input  logic         clk,
  input  logic         n_reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [3:0] WAIT_LAST = 4'd15;

  state_e      state_q;
  logic [3:0]  wait_cnt_q;
  logic        last_grant_q;
  logic        grant_id_q;
  logic [2:0]  alu_op_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic        alu_start_q;
  logic        busy_q;
  logic        resp0_valid_q;
  logic        resp1_valid_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;

  logic        grant_d;
  logic        ready0_d;
  logic        ready1_d;
  logic        accept_d;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_d  = 1'b0;
    ready0_d = 1'b0;
    ready1_d = 1'b0;
    if (bus.req0_valid_i && bus.req1_valid_i) begin
      grant_d = ~last_grant_q;
    end else begin
      grant_d = bus.req1_valid_i;
    end
    // Ready is gated by reset so every output reads zero while reset is held.
    if (n_reset && (state_q == S_IDLE)) begin
      ready0_d = bus.req0_valid_i && !grant_d;
      ready1_d = bus.req1_valid_i &&  grant_d;
    end
    accept_d = ready0_d || ready1_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= 4'd0;
      last_grant_q  <= 1'b1;
      grant_id_q    <= 1'b0;
      alu_op_q      <= 3'd0;
      alu_a_q       <= 32'd0;
      alu_b_q       <= 32'd0;
      alu_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp_data_q   <= 32'd0;
      resp_err_q    <= 1'b0;
    end else begin
      alu_start_q   <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            alu_op_q     <= grant_d ? bus.req1_op_i : bus.req0_op_i;
            alu_a_q      <= grant_d ? bus.req1_a_i  : bus.req0_a_i;
            alu_b_q      <= grant_d ? bus.req1_b_i  : bus.req0_b_i;
            grant_id_q   <= grant_d;
            last_grant_q <= grant_d;
            alu_start_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt_q <= 4'd0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // A done in the final wait cycle is checked first, so it beats the timeout.
          if (bus.alu_done_i) begin
            resp_data_q   <= bus.alu_result_i;
            resp_err_q    <= 1'b0;
            resp0_valid_q <= ~grant_id_q;
            resp1_valid_q <=  grant_id_q;
            state_q       <= S_RESP;
          end else if (wait_cnt_q == WAIT_LAST) begin
            resp_data_q   <= 32'd0;
            resp_err_q    <= 1'b1;
            resp0_valid_q <= ~grant_id_q;
            resp1_valid_q <=  grant_id_q;
            state_q       <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready_o  = ready0_d;
  assign bus.req1_ready_o  = ready1_d;
  assign bus.alu_start_o   = alu_start_q;
  assign bus.alu_op_o      = alu_op_q;
  assign bus.alu_a_o       = alu_a_q;
  assign bus.alu_b_o       = alu_b_q;
  assign bus.resp0_valid_o = resp0_valid_q;
  assign bus.resp1_valid_o = resp1_valid_q;
  assign bus.resp_data_o   = resp_data_q;
  assign bus.resp_err_o    = resp_err_q;
  assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration, ALU results and timeout.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  typedef struct {
    bit          valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  int          n_vec = 0;
  int          n_err = 0;
  req_t        rq [2];
  int          last_grant_m;
  logic [31:0] last_data_m;
  logic        last_err_m;
  logic [2:0]  iss_op_m;
  logic [31:0] iss_a_m;
  logic [31:0] iss_b_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stand-in for the shared ALU: the result it would compute for the issued operation.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic drive_reqs();
    bus.req0_valid_i = rq[0].valid;
    bus.req0_op_i    = rq[0].op;
    bus.req0_a_i     = rq[0].a;
    bus.req0_b_i     = rq[0].b;
    bus.req1_valid_i = rq[1].valid;
    bus.req1_op_i    = rq[1].op;
    bus.req1_a_i     = rq[1].a;
    bus.req1_b_i     = rq[1].b;
  endtask

  task automatic new_req(input int i);
    rq[i].valid = 1'b1;
    rq[i].op    = 3'($urandom_range(0, 7));
    rq[i].a     = $urandom;
    rq[i].b     = $urandom;
  endtask

  task automatic model_reset();
    last_grant_m = 1;
    last_data_m  = 32'd0;
    last_err_m   = 1'b0;
    iss_op_m     = 3'd0;
    iss_a_m      = 32'd0;
    iss_b_m      = 32'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready0"}, bus.req0_ready_o, 0);
    check({tag, "_ready1"}, bus.req1_ready_o, 0);
    check({tag, "_start"},  bus.alu_start_o,  0);
    check({tag, "_op"},     bus.alu_op_o,     0);
    check({tag, "_a"},      bus.alu_a_o,      0);
    check({tag, "_b"},      bus.alu_b_o,      0);
    check({tag, "_resp0"},  bus.resp0_valid_o, 0);
    check({tag, "_resp1"},  bus.resp1_valid_o, 0);
    check({tag, "_data"},   bus.resp_data_o,  0);
    check({tag, "_err"},    bus.resp_err_o,   0);
    check({tag, "_busy"},   bus.busy_o,       0);
  endtask

  // One complete transaction, entered in an IDLE cycle with requests already driven.
  // done_at: WAIT cycle index in which done is pulsed (>15 means never -> timeout).
  // noise:   also pulse done with junk data in the ISSUE and RESP cycles.
  // reissue: the granted requester immediately presents a fresh request.
  task automatic transact(input int done_at, input bit noise, input bit reissue);
    int          g;
    int          k;
    bit          fin;
    logic [31:0] exp_res;
    logic        exp_err;
    #1;
    check("idle_start", bus.alu_start_o,   0);
    check("idle_resp0", bus.resp0_valid_o, 0);
    check("idle_resp1", bus.resp1_valid_o, 0);
    check("idle_data",  bus.resp_data_o,   last_data_m);
    check("idle_err",   bus.resp_err_o,    last_err_m);
    check("idle_op",    bus.alu_op_o,      iss_op_m);
    check("idle_a",     bus.alu_a_o,       iss_a_m);
    check("idle_b",     bus.alu_b_o,       iss_b_m);
    g = (rq[0].valid && rq[1].valid) ? 1 - last_grant_m : (rq[1].valid ? 1 : 0);
    check("ready0", bus.req0_ready_o, (g == 0) && rq[0].valid);
    check("ready1", bus.req1_ready_o, (g == 1) && rq[1].valid);
    last_grant_m = g;
    iss_op_m = rq[g].op;
    iss_a_m  = rq[g].a;
    iss_b_m  = rq[g].b;
    exp_res  = alu_ref(iss_op_m, iss_a_m, iss_b_m);

    @(posedge clk); #1;
    check("issue_start", bus.alu_start_o, 1);
    check("issue_busy",  bus.busy_o,      1);
    check("issue_op",    bus.alu_op_o,    iss_op_m);
    check("issue_a",     bus.alu_a_o,     iss_a_m);
    check("issue_b",     bus.alu_b_o,     iss_b_m);
    if (reissue) new_req(g);
    else rq[g].valid = 1'b0;
    drive_reqs();
    if (noise) begin
      bus.alu_done_i   = 1'b1;
      bus.alu_result_i = $urandom;
    end
    #1;
    check("issue_ready0", bus.req0_ready_o, 0);
    check("issue_ready1", bus.req1_ready_o, 0);

    k   = 0;
    fin = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      bus.alu_done_i = 1'b0;
      check("wait_start", bus.alu_start_o,   0);
      check("wait_busy",  bus.busy_o,        1);
      check("wait_resp0", bus.resp0_valid_o, 0);
      check("wait_resp1", bus.resp1_valid_o, 0);
      if (k == done_at) begin
        bus.alu_done_i   = 1'b1;
        bus.alu_result_i = exp_res;
        fin = 1'b1;
      end else if (k == 15) begin
        fin = 1'b1;
      end
      k++;
    end

    @(posedge clk); #1;
    bus.alu_done_i = noise;
    if (noise) bus.alu_result_i = $urandom;
    exp_err     = (done_at > 15);
    last_err_m  = exp_err;
    last_data_m = exp_err ? 32'd0 : exp_res;
    check("resp0_valid", bus.resp0_valid_o, g == 0);
    check("resp1_valid", bus.resp1_valid_o, g == 1);
    check("resp_data",   bus.resp_data_o,   last_data_m);
    check("resp_err",    bus.resp_err_o,    last_err_m);
    check("resp_busy",   bus.busy_o,        1);

    @(posedge clk); #1;
    bus.alu_done_i = 1'b0;
    check("after_busy", bus.busy_o, 0);
  endtask

  initial begin
    int g;
    n_reset          = 1'b0;
    bus.alu_done_i   = 1'b0;
    bus.alu_result_i = 32'd0;
    for (int i = 0; i < 2; i++) rq[i] = '{valid: 1'b0, op: 3'd0, a: 32'd0, b: 32'd0};
    model_reset();

    // Reset holds every output at zero even with both requests pending.
    new_req(0);
    new_req(1);
    drive_reqs();
    #1;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    n_reset = 1'b1;

    // Continuous contention from reset: grants alternate starting with requester 0.
    for (int i = 0; i < 4; i++) begin
      transact(0, 1'b0, 1'b1);
      check("rr_order", last_grant_m, i % 2);
    end

    // Single requester 0 add 5 + 3, done in the first WAIT cycle.
    rq[1].valid = 1'b0;
    rq[0] = '{valid: 1'b1, op: 3'b000, a: 32'd5, b: 32'd3};
    drive_reqs();
    transact(0, 1'b0, 1'b0);
    check("add_5_3", last_data_m, 32'h0000_0008);

    // ALU never answers: timeout error after 16 WAIT cycles.
    new_req(1);
    drive_reqs();
    transact(99, 1'b0, 1'b0);

    // Done in the 16th WAIT cycle beats the timeout.
    new_req(0);
    drive_reqs();
    transact(15, 1'b0, 1'b0);

    // Done pulses outside WAIT are ignored; only the WAIT-cycle value is returned.
    rq[0] = '{valid: 1'b1, op: 3'b001, a: 32'd0, b: 32'd2};
    drive_reqs();
    transact(2, 1'b1, 1'b0);
    check("ignore_issue_done", last_data_m, 32'hFFFF_FFFE);

    // Randomized traffic; requesters never withdraw a pending request.
    for (int t = 0; t < 40; t++) begin
      int r;
      r = $urandom_range(0, 3);
      if (!rq[0].valid && r[0]) new_req(0);
      if (!rq[1].valid && r[1]) new_req(1);
      if (!rq[0].valid && !rq[1].valid) new_req($urandom_range(0, 1));
      drive_reqs();
      transact($urandom_range(0, 18), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of WAIT abandons the request with no response.
    if (!rq[0].valid) new_req(0);
    if (!rq[1].valid) new_req(1);
    drive_reqs();
    #1;
    g = 1 - last_grant_m;
    check("pre_rst_ready", g == 0 ? bus.req0_ready_o : bus.req1_ready_o, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", bus.busy_o, 1);
    n_reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_reset = 1'b1;
    model_reset();
    transact(1, 1'b0, 1'b0);
    check("post_rst_tie", last_grant_m, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have no parameters; data width fixed at 32, op width at 3, timeout fixed at 16 WAIT cycles.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 n_reset  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid_i / req1_valid_i  input  1  requester N has an ALU operation pending.
REQ-005 req0_op_i / req1_op_i  input  3  ALU opcode from requester N, passed through unmodified.
REQ-006 req0_a_i, req0_b_i / req1_a_i, req1_b_i  input  32  operands from requester N.
REQ-007 req0_ready_o / req1_ready_o  output  1  request accepted this cycle when valid && ready.
REQ-008 alu_start_o  output  1  one-cycle start pulse to the shared ALU.
REQ-009 alu_op_o  output  3  registered opcode to the ALU.
REQ-010 alu_a_o, alu_b_o  output  32  registered operands to the ALU.
REQ-011 alu_result_i  input  32  ALU result, valid when alu_done_i=1.
REQ-012 alu_done_i  input  1  ALU completion strobe.
REQ-013 resp0_valid_o / resp1_valid_o  output  1  one-cycle response strobe to requester N.
REQ-014 resp_data_o  output  32  response data, shared by both requesters.
REQ-015 resp_err_o  output  1  response is a timeout error.
REQ-016 busy_o  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one state per cycle except WAIT.
REQ-018 IDLE: ready SHALL be combinational, asserted only to the granted requester, and only if its valid is high.
REQ-019 Grant: only one valid -> that requester; both valid -> requester not equal to last_grant (round-robin).
REQ-020 On accept (valid && ready at clock edge) SHALL latch op, a, b, grant id; last_grant <= grant id; go to ISSUE.
REQ-021 ISSUE: alu_start_o=1 for exactly this cycle with latched op/a/b; next state WAIT; wait counter <= 0.
REQ-022 alu_op_o/alu_a_o/alu_b_o SHALL hold latched values from ISSUE until next accept.
REQ-023 WAIT: alu_done_i=1 -> capture alu_result_i, err<=0, go RESP; else counter increments.
REQ-024 WAIT: done absent for 16 consecutive WAIT cycles -> data<=0, err<=1, go RESP; done in the 16th cycle wins over timeout.
REQ-025 alu_done_i SHALL be ignored in IDLE, ISSUE and RESP.
REQ-026 RESP: resp<id>_valid_o=1 for one cycle only for the granted id; resp_data_o/resp_err_o SHALL hold until the next RESP.
REQ-027 Latency: accept at edge N -> alu_start_o in cycle N+1 -> earliest resp valid at cycle N+3 (done in first WAIT cycle).
REQ-028 ready SHALL be 0 to both requesters outside IDLE; at most one request in flight.
REQ-029 Requester SHALL hold valid and operands stable until ready; arbiter never drops an asserted valid.

Reset
REQ-030 n_reset low SHALL immediately force state IDLE, counter 0, last_grant=1 (requester 0 wins first tie).
REQ-031 During reset all outputs SHALL be 0, including alu_op_o, alu_a_o, alu_b_o, resp_data_o.
REQ-032 Reset mid-operation SHALL abandon the request without response; first post-reset tie goes to requester 0.

Verification
REQ-033 Single req0 op=3'b000 a=5 b=3; ALU done one cycle after start with 8 -> resp0_valid at accept+3, data 0x00000008, err 0.
REQ-034 Both valid from reset, continuously -> grants alternate 0,1,0,1; no resp1 ever precedes the first resp0.
REQ-035 ALU never asserts done -> resp_err_o=1, resp_data_o=0 exactly 16 cycles after first WAIT cycle; busy_o drops next cycle.
REQ-036 done pulsed during ISSUE and again in WAIT with 0xFFFFFFFE -> only WAIT value 0xFFFFFFFE returned.
REQ-037 n_reset asserted in WAIT -> outputs 0 at once, no response; after release tie grants requester 0.
